// File: rtl/scroll_writer.sv
// ---------------------------------------------------------------------------
// scroll_writer
//
// Purpose:
//   Turns a stream of character codes into VRAM writes for a scrolling text
//   terminal. The screen is a ring of ROWS physical rows. top_row names the
//   physical row that is shown as the first display line, so scrolling only
//   moves top_row and blanks one row. No text is copied.
//
// Ports:
//   clk              in   1  rising-edge clock
//   reset_low        in   1  asynchronous active-low reset
//   character_ready  out  1  high in IDLE; a character may be accepted
//   character_valid  in   1  character_byte is valid
//   character_byte   in   8  incoming character code
//   write_ready      in   1  VRAM accepts a write this cycle
//   write_valid      out  1  a VRAM write is pending
//   write_row        out  5  physical VRAM row of the write
//   write_col        out  7  VRAM column of the write
//   write_byte       out  8  byte to store
//   top_row          out  5  physical row shown as the first display line
// ---------------------------------------------------------------------------
module scroll_writer #(
  parameter int         ROWS      = 24,
  parameter int         COLS      = 80,
  parameter int         TAB_WIDTH = 8,
  parameter logic [7:0] BLANK     = 8'h20
) (
  input  logic       clk,
  input  logic       reset_low,
  output logic       character_ready,
  input  logic       character_valid,
  input  logic [7:0] character_byte,
  input  logic       write_ready,
  output logic       write_valid,
  output logic [4:0] write_row,
  output logic [6:0] write_col,
  output logic [7:0] write_byte,
  output logic [4:0] top_row
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [5:0] ROWS_W   = 6'(ROWS);
  localparam logic [7:0] TAB_MASK = 8'(TAB_WIDTH - 1);
  localparam logic [7:0] TAB_STEP = 8'(TAB_WIDTH);

  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_HT = 8'h09;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    WRITE,
    CLEAR_LINE
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] cur_row_q, cur_row_d;
  logic [6:0] cur_col_q, cur_col_d;
  logic [4:0] top_row_q, top_row_d;
  logic [4:0] wr_row_q, wr_row_d;
  logic [6:0] wr_col_q, wr_col_d;
  logic [7:0] wr_byte_q, wr_byte_d;
  logic       valid_q, valid_d;

  logic       xfer;
  logic       do_newline;
  logic [5:0] row_sum;
  logic [4:0] phys_row;
  logic [4:0] next_top;
  logic [7:0] tab_raw;
  logic [6:0] tab_col;

  // Derived positions. The cursor row is mapped onto the ring of physical
  // rows, the next top row wraps, and the tab target is clamped to the last
  // column.
  always_comb begin
    row_sum  = {1'b0, top_row_q} + {1'b0, cur_row_q};
    phys_row = (row_sum >= ROWS_W) ? 5'(row_sum - ROWS_W) : 5'(row_sum);
    next_top = (top_row_q == LAST_ROW) ? 5'd0 : top_row_q + 5'd1;
    tab_raw  = ({1'b0, cur_col_q} & ~TAB_MASK) + TAB_STEP;
    tab_col  = (tab_raw > {1'b0, LAST_COL}) ? LAST_COL : tab_raw[6:0];
  end

  assign xfer            = valid_q && write_ready;
  assign character_ready = (state_q == IDLE);
  assign write_valid     = valid_q;
  assign write_row       = wr_row_q;
  assign write_col       = wr_col_q;
  assign write_byte      = wr_byte_q;
  assign top_row         = top_row_q;

  // Next-state logic. The write address registers are also the sweep
  // counters for both clear states. They change only on a transfer, so a
  // pending write stays stable while VRAM stalls. A newline request from a
  // character or from an auto-wrap is resolved in one place at the end.
  always_comb begin
    state_d    = state_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    top_row_d  = top_row_q;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_byte_d  = wr_byte_q;
    do_newline = 1'b0;

    case (state_q)
      CLEAR_ALL: begin
        if (xfer) begin
          if (wr_col_q == LAST_COL) begin
            wr_col_d = 7'd0;
            if (wr_row_q == LAST_ROW) begin
              wr_row_d = 5'd0;
              state_d  = IDLE;
            end else begin
              wr_row_d = wr_row_q + 5'd1;
            end
          end else begin
            wr_col_d = wr_col_q + 7'd1;
          end
        end
      end

      IDLE: begin
        if (character_valid) begin
          if (character_byte >= 8'h20 && character_byte <= 8'h7E) begin
            state_d   = WRITE;
            wr_row_d  = phys_row;
            wr_col_d  = cur_col_q;
            wr_byte_d = character_byte;
          end else if (character_byte == CHAR_CR) begin
            cur_col_d = 7'd0;
          end else if (character_byte == CHAR_LF) begin
            do_newline = 1'b1;
          end else if (character_byte == CHAR_BS) begin
            if (cur_col_q != 7'd0) begin
              cur_col_d = cur_col_q - 7'd1;
            end
          end else if (character_byte == CHAR_HT) begin
            cur_col_d = tab_col;
          end
        end
      end

      WRITE: begin
        if (xfer) begin
          if (cur_col_q < LAST_COL) begin
            cur_col_d = cur_col_q + 7'd1;
            state_d   = IDLE;
          end else begin
            cur_col_d  = 7'd0;
            do_newline = 1'b1;
          end
        end
      end

      CLEAR_LINE: begin
        if (xfer) begin
          if (wr_col_q == LAST_COL) begin
            state_d = IDLE;
          end else begin
            wr_col_d = wr_col_q + 7'd1;
          end
        end
      end

      default: state_d = CLEAR_ALL;
    endcase

    // A newline on the bottom row scrolls. The old top row becomes the new
    // bottom row, so that row is the one blanked.
    if (do_newline) begin
      if (cur_row_q != LAST_ROW) begin
        cur_row_d = cur_row_q + 5'd1;
        state_d   = IDLE;
      end else begin
        top_row_d = next_top;
        wr_row_d  = top_row_q;
        wr_col_d  = 7'd0;
        wr_byte_d = BLANK;
        state_d   = CLEAR_LINE;
      end
    end

    valid_d = (state_d != IDLE);
  end

  // State and datapath registers. write_valid is registered, so it stays low
  // while reset is held. It rises on the first edge after reset is released.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q   <= CLEAR_ALL;
      cur_row_q <= 5'd0;
      cur_col_q <= 7'd0;
      top_row_q <= 5'd0;
      wr_row_q  <= 5'd0;
      wr_col_q  <= 7'd0;
      wr_byte_q <= BLANK;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      top_row_q <= top_row_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_byte_q <= wr_byte_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_scroll_writer.sv
// ---------------------------------------------------------------------------
// tb_scroll_writer
//
// Drives characters into a small 4x8 scroll_writer. A terminal model works
// out which VRAM writes each character must cause and queues them. An
// independent monitor pops and compares every write that transfers.
// ---------------------------------------------------------------------------
module tb_scroll_writer;

  localparam int         R      = 4;
  localparam int         C      = 8;
  localparam int         TW     = 4;
  localparam logic [7:0] BLANKB = 8'h20;

  logic       clk = 1'b0;
  logic       reset_low = 1'b0;
  logic       character_ready;
  logic       character_valid = 1'b0;
  logic [7:0] character_byte = 8'h00;
  logic       write_ready = 1'b0;
  logic       write_valid;
  logic [4:0] write_row;
  logic [6:0] write_col;
  logic [7:0] write_byte;
  logic [4:0] top_row;

  int checks = 0;
  int failures = 0;
  int readyMode = 0;

  logic [19:0] expQ[$];

  int modelRow = 0;
  int modelCol = 0;
  int modelTop = 0;

  scroll_writer #(
    .ROWS(R),
    .COLS(C),
    .TAB_WIDTH(TW),
    .BLANK(BLANKB)
  ) dut (
    .clk(clk),
    .reset_low(reset_low),
    .character_ready(character_ready),
    .character_valid(character_valid),
    .character_byte(character_byte),
    .write_ready(write_ready),
    .write_valid(write_valid),
    .write_row(write_row),
    .write_col(write_col),
    .write_byte(write_byte),
    .top_row(top_row)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Drives write_ready a little after each rising edge.
  // Mode 0 holds it high, mode 1 randomises it, and mode 2 holds it low.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       write_ready = 1'b1;
      1:       write_ready = ($urandom_range(0, 3) != 0);
      default: write_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Terminal model. It tracks the cursor as a plain row and column on the
  // visible screen, and tracks top_row as a rotation of the ring of rows.
  function automatic void pushWrite(input int r, input int c, input logic [7:0] b);
    expQ.push_back({5'(r), 7'(c), b});
  endfunction

  function automatic void modelNewline();
    int oldTop;
    if (modelRow < R - 1) begin
      modelRow++;
    end else begin
      oldTop   = modelTop;
      modelTop = (modelTop + 1) % R;
      for (int c = 0; c < C; c++) pushWrite(oldTop, c, BLANKB);
    end
  endfunction

  function automatic void modelChar(input logic [7:0] b);
    int nextStop;
    if (b >= 8'h20 && b <= 8'h7E) begin
      pushWrite((modelTop + modelRow) % R, modelCol, b);
      if (modelCol < C - 1) begin
        modelCol++;
      end else begin
        modelCol = 0;
        modelNewline();
      end
    end else if (b == 8'h0D) begin
      modelCol = 0;
    end else if (b == 8'h0A) begin
      modelNewline();
    end else if (b == 8'h08) begin
      if (modelCol > 0) modelCol--;
    end else if (b == 8'h09) begin
      nextStop = ((modelCol / TW) + 1) * TW;
      modelCol = (nextStop > C - 1) ? C - 1 : nextStop;
    end
  endfunction

  // Scoreboard monitor. It checks every write that will transfer on the next
  // rising edge against the oldest write the model predicted.
  always @(negedge clk) begin
    logic [19:0] exp;
    if (reset_low && write_valid && write_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", 1, 0);
      end else begin
        exp = expQ.pop_front();
        checkOutput("write", int'({write_row, write_col, write_byte}), int'(exp));
      end
    end
  end

  // Hard stop in case some wait was left unbounded.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitIdle();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (character_ready && expQ.size() == 0) done = 1;
    end
    if (!done) checkOutput("idle_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bit accepted = 0;
    @(posedge clk);
    #1;
    character_valid = 1'b1;
    character_byte  = b;
    for (int i = 0; i < 3000 && !accepted; i++) begin
      @(negedge clk);
      if (character_ready) begin
        modelChar(b);
        accepted = 1;
      end
    end
    @(posedge clk);
    #1;
    character_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic doReset();
    reset_low = 1'b0;
    expQ.delete();
    modelRow = 0;
    modelCol = 0;
    modelTop = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_write_valid", int'(write_valid), 0);
    checkOutput("rst_char_ready", int'(character_ready), 0);
    checkOutput("rst_top_row", int'(top_row), 0);
    checkOutput("rst_write_row", int'(write_row), 0);
    checkOutput("rst_write_col", int'(write_col), 0);
    checkOutput("rst_write_byte", int'(write_byte), int'(BLANKB));
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) pushWrite(r, c, BLANKB);
    @(posedge clk);
    #2;
    reset_low = 1'b1;
  endtask

  task automatic sendString(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
  endtask

  initial begin
    logic [7:0] b;
    logic [19:0] held;
    int k;

    $display("[TB] start");
    readyMode = 0;
    doReset();
    waitIdle();
    checkOutput("clear_all_top_row", int'(top_row), 0);
    checkOutput("clear_all_ready", int'(character_ready), 1);

    // Basic printing, carriage return and line feed.
    applyStimulus("A");
    applyStimulus("B");
    applyStimulus(8'h0D);
    @(negedge clk);
    checkOutput("cr_keeps_ready", int'(character_ready), 1);
    applyStimulus(8'h0A);
    applyStimulus("C");
    waitIdle();

    // A full line wraps to the next row.
    applyStimulus(8'h0D);
    sendString("01234567");
    applyStimulus("D");
    waitIdle();

    // Move to the bottom row, then scroll.
    while (modelRow < R - 1) applyStimulus(8'h0A);
    applyStimulus(8'h0A);
    waitIdle();
    checkOutput("scroll_top_row", int'(top_row), modelTop);
    applyStimulus("X");
    waitIdle();

    // Stall the VRAM during a character write.
    readyMode = 2;
    applyStimulus("Q");
    held = expQ[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", int'(write_valid), 1);
      checkOutput("stall_ready", int'(character_ready), 0);
      checkOutput("stall_hold", int'({write_row, write_col, write_byte}), int'(held));
    end
    readyMode = 0;
    waitIdle();

    // Backspace at column 0 does nothing.
    applyStimulus(8'h0D);
    applyStimulus(8'h08);
    applyStimulus("Z");
    applyStimulus(8'h09);
    applyStimulus("T");
    waitIdle();

    // Random characters with random VRAM back-pressure.
    readyMode = 1;
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 11);
      case (k)
        0, 1, 2, 3, 4: b = 8'($urandom_range(32, 126));
        5:             b = 8'h0D;
        6, 7:          b = 8'h0A;
        8:             b = 8'h08;
        9:             b = 8'h09;
        10:            b = 8'($urandom_range(0, 31));
        default:       b = 8'($urandom_range(127, 255));
      endcase
      applyStimulus(b);
      if (n % 25 == 24) begin
        waitIdle();
        checkOutput("rand_top_row", int'(top_row), modelTop);
      end
    end
    waitIdle();

    // Reset during a line clear abandons the clear and starts over.
    while (modelRow < R - 1) applyStimulus(8'h0A);
    applyStimulus(8'h0A);
    @(posedge clk);
    #2;
    reset_low = 1'b0;
    #1;
    checkOutput("midrst_write_valid", int'(write_valid), 0);
    checkOutput("midrst_top_row", int'(top_row), 0);
    doReset();
    waitIdle();
    checkOutput("post_rst_top_row", int'(top_row), 0);
    applyStimulus("X");
    waitIdle();

    checkOutput("queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
